// File: rtl/bp_be_late_wb_arbiter_pkg.sv
// Shared types and constants for the late-writeback arbiter slice.
// The writeback packet mirrors the bp_be internal-interface packet so the
// arbiter drops straight into the existing regfile write path.
package bp_be_late_wb_arbiter_pkg;

    typedef enum logic [3:0] {
        e_bp_default_cfg = 4'd0
    } bp_params_e;

    localparam int reg_addr_width_gp = 5;
    localparam int dword_width_gp    = 64;
    localparam int fflags_width_gp   = 5;
    // One pending-write bit per architectural register.
    localparam int score_width_gp    = 32;

    typedef struct packed {
        logic                         ird_w_v;
        logic                         frd_w_v;
        logic                         late;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dword_width_gp-1:0]    rd_data;
        logic                         fflags_w_v;
        logic [fflags_width_gp-1:0]   fflags;
    } bp_be_wb_pkt_s;

    // Packet width for a processor configuration.
    function automatic int wb_pkt_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: wb_pkt_width_f = $bits(bp_be_wb_pkt_s);
            default:          wb_pkt_width_f = $bits(bp_be_wb_pkt_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_be_late_wb_arbiter_if.sv
// Bundle of the late-writeback sources, regfile write outputs and scoreboards.
//
// Handshake: each source presents pkt with v_i=1 and keeps both stable until
// the arbiter answers yumi_o=1 in the same cycle; the transfer happens on that
// clock edge. yumi_o is a combinational function of v_i and never rises while
// v_i=0. The regfile outputs (wb_pkt_o/wb_v_o) carry no backpressure.
interface bp_be_late_wb_arbiter_if;
    import bp_be_late_wb_arbiter_pkg::*;

    bp_be_wb_pkt_s                 long_iwb_pkt_i;
    logic                          long_iwb_v_i;
    logic                          long_iwb_yumi_o;
    bp_be_wb_pkt_s                 long_fwb_pkt_i;
    logic                          long_fwb_v_i;
    logic                          long_fwb_yumi_o;
    bp_be_wb_pkt_s                 mem_iwb_pkt_i;
    logic                          mem_iwb_v_i;
    logic                          mem_iwb_yumi_o;
    bp_be_wb_pkt_s                 mem_fwb_pkt_i;
    logic                          mem_fwb_v_i;
    logic                          mem_fwb_yumi_o;
    logic                          irf_busy_i;
    logic                          frf_busy_i;
    logic                          issue_v_i;
    logic                          issue_fp_i;
    logic [reg_addr_width_gp-1:0]  issue_rd_addr_i;
    bp_be_wb_pkt_s                 iwb_pkt_o;
    logic                          iwb_v_o;
    bp_be_wb_pkt_s                 fwb_pkt_o;
    logic                          fwb_v_o;
    logic [score_width_gp-1:0]     iscore_o;
    logic [score_width_gp-1:0]     fscore_o;
    logic                          fflags_clear_i;
    logic [fflags_width_gp-1:0]    fflags_o;

    modport master (
        output long_iwb_pkt_i, long_iwb_v_i, long_fwb_pkt_i, long_fwb_v_i,
        output mem_iwb_pkt_i, mem_iwb_v_i, mem_fwb_pkt_i, mem_fwb_v_i,
        output irf_busy_i, frf_busy_i, issue_v_i, issue_fp_i, issue_rd_addr_i,
        output fflags_clear_i,
        input  long_iwb_yumi_o, long_fwb_yumi_o, mem_iwb_yumi_o, mem_fwb_yumi_o,
        input  iwb_pkt_o, iwb_v_o, fwb_pkt_o, fwb_v_o, iscore_o, fscore_o, fflags_o
    );

    modport slave (
        input  long_iwb_pkt_i, long_iwb_v_i, long_fwb_pkt_i, long_fwb_v_i,
        input  mem_iwb_pkt_i, mem_iwb_v_i, mem_fwb_pkt_i, mem_fwb_v_i,
        input  irf_busy_i, frf_busy_i, issue_v_i, issue_fp_i, issue_rd_addr_i,
        input  fflags_clear_i,
        output long_iwb_yumi_o, long_fwb_yumi_o, mem_iwb_yumi_o, mem_fwb_yumi_o,
        output iwb_pkt_o, iwb_v_o, fwb_pkt_o, fwb_v_o, iscore_o, fscore_o, fflags_o
    );

endinterface

// File: rtl/bp_be_late_wb_slice.sv
// One register file's late-writeback path: 2:1 round-robin between the long
// pipe and the memory pipe, the registered regfile write, and the
// pending-late-write scoreboard for that file.
module bp_be_late_wb_slice
    import bp_be_late_wb_arbiter_pkg::*;
#(
    parameter int pkt_width_p = $bits(bp_be_wb_pkt_s),
    // Integer file: x0 is hardwired, so it never becomes pending.
    parameter bit no_r0_p     = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [pkt_width_p-1:0]        i_long_pkt,
    input  logic                          i_long_v,
    output logic                          o_long_yumi,
    input  logic [pkt_width_p-1:0]        i_mem_pkt,
    input  logic                          i_mem_v,
    output logic                          o_mem_yumi,
    input  logic                          i_busy,
    input  logic                          i_set_v,
    input  logic [reg_addr_width_gp-1:0]  i_set_addr,
    output logic [pkt_width_p-1:0]        o_wb_pkt,
    output logic                          o_wb_v,
    output logic [score_width_gp-1:0]     o_score,
    output logic [fflags_width_gp-1:0]    o_grant_fflags
);

    bp_be_wb_pkt_s               w_long_pkt;
    bp_be_wb_pkt_s               w_mem_pkt;
    bp_be_wb_pkt_s               w_gnt_pkt;
    logic                        w_req_long;
    logic                        w_req_mem;
    logic                        w_gnt_long;
    logic                        w_gnt_mem;
    logic                        w_gnt;
    logic [score_width_gp-1:0]   w_set_mask;
    logic [score_width_gp-1:0]   w_clr_mask;

    // Round-robin state: 0 -> long wins a tie, 1 -> mem wins a tie.
    logic                        r_prio_mem;
    bp_be_wb_pkt_s               r_pkt;
    logic                        r_v;
    logic [score_width_gp-1:0]   r_score;

    assign w_long_pkt = bp_be_wb_pkt_s'(i_long_pkt);
    assign w_mem_pkt  = bp_be_wb_pkt_s'(i_mem_pkt);

    // A busy write port stalls both sources; reset silences every yumi.
    assign w_req_long = i_long_v & ~i_busy & ~reset_i;
    assign w_req_mem  = i_mem_v  & ~i_busy & ~reset_i;
    assign w_gnt_long = w_req_long & (~w_req_mem | ~r_prio_mem);
    assign w_gnt_mem  = w_req_mem & ~w_gnt_long;
    assign w_gnt      = w_gnt_long | w_gnt_mem;

    assign o_long_yumi = w_gnt_long;
    assign o_mem_yumi  = w_gnt_mem;

    // Select the granted packet and mark it as a late write.
    always_comb begin
        w_gnt_pkt      = w_gnt_long ? w_long_pkt : w_mem_pkt;
        w_gnt_pkt.late = 1'b1;
    end

    // Scoreboard set/clear masks for this cycle.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_v && !(no_r0_p && (i_set_addr == '0))) begin
            w_set_mask[i_set_addr] = 1'b1;
        end
        if (w_gnt) begin
            w_clr_mask[w_gnt_pkt.rd_addr] = 1'b1;
        end
    end

    assign o_grant_fflags = (w_gnt && w_gnt_pkt.fflags_w_v) ? w_gnt_pkt.fflags : '0;

    // Flip the tie-break toward the other source after every grant.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_prio_mem <= 1'b0;
        end else if (w_gnt) begin
            r_prio_mem <= w_gnt_long;
        end
    end

    // Registered regfile write; the packet holds while no write is issued.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v   <= 1'b0;
            r_pkt <= '0;
        end else begin
            r_v <= w_gnt;
            if (w_gnt) begin
                r_pkt <= w_gnt_pkt;
            end
        end
    end

    // Pending-write scoreboard; a same-cycle set overrides the clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_score <= '0;
        end else begin
            r_score <= (r_score & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_wb_pkt = r_pkt;
    assign o_wb_v   = r_v;
    assign o_score  = r_score;

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Late-writeback arbiter: independent integer and FP slices plus the
// accumulated floating-point exception flags.
module bp_be_late_wb_arbiter
    import bp_be_late_wb_arbiter_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_be_late_wb_arbiter_if.slave  bus
);

    localparam int wb_pkt_width_lp = wb_pkt_width_f(bp_params_p);

    logic [fflags_width_gp-1:0] w_iflags;
    logic [fflags_width_gp-1:0] w_fflags;
    logic [fflags_width_gp-1:0] w_flags;
    logic [fflags_width_gp-1:0] r_fflags;

    bp_be_late_wb_slice #(
        .pkt_width_p (wb_pkt_width_lp),
        .no_r0_p     (1'b1)
    ) u_int (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .i_long_pkt     (bus.long_iwb_pkt_i),
        .i_long_v       (bus.long_iwb_v_i),
        .o_long_yumi    (bus.long_iwb_yumi_o),
        .i_mem_pkt      (bus.mem_iwb_pkt_i),
        .i_mem_v        (bus.mem_iwb_v_i),
        .o_mem_yumi     (bus.mem_iwb_yumi_o),
        .i_busy         (bus.irf_busy_i),
        .i_set_v        (bus.issue_v_i & ~bus.issue_fp_i),
        .i_set_addr     (bus.issue_rd_addr_i),
        .o_wb_pkt       (bus.iwb_pkt_o),
        .o_wb_v         (bus.iwb_v_o),
        .o_score        (bus.iscore_o),
        .o_grant_fflags (w_iflags)
    );

    bp_be_late_wb_slice #(
        .pkt_width_p (wb_pkt_width_lp),
        .no_r0_p     (1'b0)
    ) u_fp (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .i_long_pkt     (bus.long_fwb_pkt_i),
        .i_long_v       (bus.long_fwb_v_i),
        .o_long_yumi    (bus.long_fwb_yumi_o),
        .i_mem_pkt      (bus.mem_fwb_pkt_i),
        .i_mem_v        (bus.mem_fwb_v_i),
        .o_mem_yumi     (bus.mem_fwb_yumi_o),
        .i_busy         (bus.frf_busy_i),
        .i_set_v        (bus.issue_v_i & bus.issue_fp_i),
        .i_set_addr     (bus.issue_rd_addr_i),
        .o_wb_pkt       (bus.fwb_pkt_o),
        .o_wb_v         (bus.fwb_v_o),
        .o_score        (bus.fscore_o),
        .o_grant_fflags (w_fflags)
    );

    assign w_flags = w_iflags | w_fflags;

    // Accumulate granted flags; a clear keeps only this cycle's flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_fflags <= '0;
        end else if (bus.fflags_clear_i) begin
            r_fflags <= w_flags;
        end else begin
            r_fflags <= r_fflags | w_flags;
        end
    end

    assign bus.fflags_o = r_fflags;

endmodule
